// File: rtl/coin_acceptor_fsm_pkg.sv
// Shared coin codes and acceptor state encoding for the vending front-end.
// Contents: coin code constants, acceptor FSM state enum, sensor-pattern-to-code helper.
package coin_acceptor_fsm_pkg;

  typedef logic [1:0] coin_code_t;

  // Coin codes understood by vending_machine_fsm.coin_in
  localparam coin_code_t COIN_NONE = 2'b00;
  localparam coin_code_t COIN_ONE  = 2'b10;
  localparam coin_code_t COIN_TWO  = 2'b11;

  typedef enum logic [1:0] {
    ACC_IDLE    = 2'd0,
    ACC_QUAL    = 2'd1,
    ACC_REJECT  = 2'd2,
    ACC_RELEASE = 2'd3
  } acc_state_e;

  // Map a stable single-sensor pattern {s1, s2} to its coin code
  function automatic coin_code_t pattern_to_code(input logic [1:0] pat);
    case (pat)
      2'b10:   return COIN_ONE;
      2'b01:   return COIN_TWO;
      default: return COIN_NONE;
    endcase
  endfunction

endpackage

// File: rtl/coin_acceptor_fsm_fifo.sv
// Synchronous FIFO holding qualified coin codes until they can be issued.
// Ports: clock, reset (async, active-high), push_i/data_i write side,
//        pop_i read side, head_c (current head), full_c, empty_c, count_o (registered).
module coin_acceptor_fsm_fifo #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic [DATA_W-1:0]        data_i,
  input  logic                     pop_i,
  output logic [DATA_W-1:0]        head_c,
  output logic                     full_c,
  output logic                     empty_c,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic              do_push;
  logic              do_pop;

  assign full_c  = (count_q == CNT_W'(DEPTH));
  assign empty_c = (count_q == '0);
  assign head_c  = mem_q[rd_ptr_q];

  // A full FIFO still accepts a push when the head leaves in the same cycle
  assign do_pop  = pop_i && !empty_c;
  assign do_push = push_i && (!full_c || do_pop);

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Storage needs no reset; validity is tracked by count_q
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  assign count_o = count_q;

endmodule

// File: rtl/coin_acceptor_fsm.sv
// Coin acceptor front-end: synchronises and debounces the two slot sensors,
// classifies coins, queues them and issues single-cycle codes to the vend FSM.
// Ports: clock, reset (async, active-high), sense_one/sense_two (raw sensors),
//        vend_busy (vend FSM dispensing), coin_code (registered code pulse),
//        coin_reject (registered one-cycle pulse), fifo_count (queued coins).
module coin_acceptor_fsm
  import coin_acceptor_fsm_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter int unsigned CNT_W           = 5
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          sense_one,
  input  logic                          sense_two,
  input  logic                          vend_busy,
  output logic [1:0]                    coin_code,
  output logic                          coin_reject,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  logic             s1_meta_q, s1_q;
  logic             s2_meta_q, s2_q;
  acc_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       pat_q, pat_d;
  logic             reject_q, reject_d;
  coin_code_t       code_q, code_d;

  logic             push_c;
  logic             issue_c;
  logic             fifo_full_c;
  logic             fifo_empty_c;
  coin_code_t       fifo_head_c;

  // Two-flop synchronisers for the asynchronous sensors
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_meta_q <= 1'b0;
      s1_q      <= 1'b0;
      s2_meta_q <= 1'b0;
      s2_q      <= 1'b0;
    end else begin
      s1_meta_q <= sense_one;
      s1_q      <= s1_meta_q;
      s2_meta_q <= sense_two;
      s2_q      <= s2_meta_q;
    end
  end

  // Issue only into a 00 gap so the previous coin's product_out can reach vend_busy
  assign issue_c = !fifo_empty_c && !vend_busy && (code_q == COIN_NONE);

  // Acceptor next-state logic; the IDLE cycle counts as the first stable sample
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pat_d    = pat_q;
    reject_d = 1'b0;
    push_c   = 1'b0;
    code_d   = issue_c ? fifo_head_c : COIN_NONE;
    case (state_q)
      ACC_IDLE: begin
        if (s1_q || s2_q) begin
          state_d = ACC_QUAL;
          cnt_d   = '0;
          pat_d   = {s1_q, s2_q};
        end
      end
      ACC_QUAL: begin
        if (s1_q && s2_q) begin
          state_d  = ACC_REJECT;
          reject_d = 1'b1;
          cnt_d    = '0;
        end else if (!s1_q && !s2_q) begin
          state_d = ACC_IDLE;
          cnt_d   = '0;
        end else if ({s1_q, s2_q} != pat_q) begin
          cnt_d = '0;
          pat_d = {s1_q, s2_q};
        end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 2)) begin
          state_d = ACC_RELEASE;
          cnt_d   = '0;
          if (fifo_full_c && !issue_c) reject_d = 1'b1;
          else                         push_c   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ACC_REJECT: begin
        state_d = ACC_RELEASE;
        cnt_d   = '0;
      end
      ACC_RELEASE: begin
        // Wait for the coin to clear the slot so it is counted only once
        if (s1_q || s2_q) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          state_d = ACC_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ACC_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ACC_IDLE;
      cnt_q    <= '0;
      pat_q    <= 2'b00;
      reject_q <= 1'b0;
      code_q   <= COIN_NONE;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pat_q    <= pat_d;
      reject_q <= reject_d;
      code_q   <= code_d;
    end
  end

  coin_acceptor_fsm_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (2)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push_i  (push_c),
    .data_i  (pattern_to_code(pat_q)),
    .pop_i   (issue_c),
    .head_c  (fifo_head_c),
    .full_c  (fifo_full_c),
    .empty_c (fifo_empty_c),
    .count_o (fifo_count)
  );

  assign coin_code   = code_q;
  assign coin_reject = reject_q;

endmodule

// File: tb/tb_coin_acceptor_fsm.sv
// Directed bench for coin_acceptor_fsm with DEBOUNCE_CYCLES=4, FIFO_DEPTH=4.
module tb_coin_acceptor_fsm;

  logic       clock = 1'b0;
  logic       reset;
  logic       sense_one;
  logic       sense_two;
  logic       vend_busy;
  logic [1:0] coin_code;
  logic       coin_reject;
  logic [2:0] fifo_count;

  int checks   = 0;
  int failures = 0;

  // Output-event monitor counters
  int n_one  = 0;
  int n_two  = 0;
  int n_bad  = 0;
  int n_gap  = 0;
  int n_busy = 0;
  int n_rej  = 0;
  logic [1:0] prev_code = 2'b00;

  int b_one, b_two, b_rej;

  coin_acceptor_fsm #(
    .DEBOUNCE_CYCLES (4),
    .FIFO_DEPTH      (4),
    .CNT_W           (3)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .sense_one   (sense_one),
    .sense_two   (sense_two),
    .vend_busy   (vend_busy),
    .coin_code   (coin_code),
    .coin_reject (coin_reject),
    .fifo_count  (fifo_count)
  );

  always #5 clock = ~clock;

  // Sample on the falling edge, away from the active edge
  always @(negedge clock) begin
    if (coin_code == 2'b10) n_one <= n_one + 1;
    if (coin_code == 2'b11) n_two <= n_two + 1;
    if (coin_code == 2'b01) n_bad <= n_bad + 1;
    if (coin_code != 2'b00 && prev_code != 2'b00) n_gap <= n_gap + 1;
    if (coin_code != 2'b00 && vend_busy) n_busy <= n_busy + 1;
    if (coin_reject) n_rej <= n_rej + 1;
    prev_code <= coin_code;
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic snap();
    b_one = n_one;
    b_two = n_two;
    b_rej = n_rej;
  endtask

  // Hold one sensor (or both) high for 'hold' cycles, then low for 'gap' cycles
  task automatic insert(input logic one, input logic two, input int hold, input int gap);
    sense_one = one;
    sense_two = two;
    tick(hold);
    sense_one = 1'b0;
    sense_two = 1'b0;
    tick(gap);
  endtask

  initial begin
    reset     = 1'b1;
    sense_one = 1'b0;
    sense_two = 1'b0;
    vend_busy = 1'b0;
    tick(2);
    check_eq("rst_code", int'(coin_code), 0);
    check_eq("rst_reject", int'(coin_reject), 0);
    check_eq("rst_count", int'(fifo_count), 0);
    reset = 1'b0;
    tick(3);

    // 1: clean one-rupee coin
    snap();
    insert(1'b1, 1'b0, 10, 20);
    check_eq("t1_ones", n_one - b_one, 1);
    check_eq("t1_twos", n_two - b_two, 0);
    check_eq("t1_reject", n_rej - b_rej, 0);
    check_eq("t1_count", int'(fifo_count), 0);

    // 2: glitch-only, then bounce followed by a stable two-rupee coin
    snap();
    for (int i = 0; i < 3; i++) insert(1'b0, 1'b1, 1, 2);
    tick(10);
    check_eq("t2_glitch_codes", (n_one - b_one) + (n_two - b_two), 0);
    snap();
    insert(1'b0, 1'b1, 1, 1);
    insert(1'b0, 1'b1, 1, 1);
    insert(1'b0, 1'b1, 6, 20);
    check_eq("t2_bounce_twos", n_two - b_two, 1);
    check_eq("t2_bounce_ones", n_one - b_one, 0);

    // 3: one-rupee coin held back while the vend FSM is busy
    snap();
    insert(1'b0, 1'b1, 10, 0);
    vend_busy = 1'b1;
    tick(20);
    insert(1'b1, 1'b0, 10, 20);
    check_eq("t3_twos", n_two - b_two, 1);
    check_eq("t3_held_ones", n_one - b_one, 0);
    check_eq("t3_held_count", int'(fifo_count), 1);
    vend_busy = 1'b0;
    tick(5);
    check_eq("t3_ones", n_one - b_one, 1);
    check_eq("t3_count", int'(fifo_count), 0);

    // 4: fill the queue while busy, fifth coin is rejected
    snap();
    vend_busy = 1'b1;
    for (int i = 0; i < 4; i++) insert(1'b0, 1'b1, 8, 20);
    check_eq("t4_full_count", int'(fifo_count), 4);
    check_eq("t4_no_reject", n_rej - b_rej, 0);
    insert(1'b0, 1'b1, 8, 20);
    check_eq("t4_reject", n_rej - b_rej, 1);
    check_eq("t4_still_full", int'(fifo_count), 4);
    check_eq("t4_no_issue", n_two - b_two, 0);
    vend_busy = 1'b0;
    tick(20);
    check_eq("t4_twos", n_two - b_two, 4);
    check_eq("t4_drained", int'(fifo_count), 0);

    // 5: both sensors high together
    snap();
    insert(1'b1, 1'b1, 8, 20);
    check_eq("t5_reject", n_rej - b_rej, 1);
    check_eq("t5_count", int'(fifo_count), 0);
    check_eq("t5_codes", (n_one - b_one) + (n_two - b_two), 0);

    // 6: reset with coins queued and the FSM qualifying a coin
    vend_busy = 1'b1;
    insert(1'b1, 1'b0, 8, 20);
    insert(1'b1, 1'b0, 8, 20);
    check_eq("t6_queued", int'(fifo_count), 2);
    sense_one = 1'b1;
    tick(4);
    reset     = 1'b1;
    sense_one = 1'b0;
    #1;
    check_eq("t6_rst_code", int'(coin_code), 0);
    check_eq("t6_rst_count", int'(fifo_count), 0);
    snap();
    tick(2);
    reset     = 1'b0;
    vend_busy = 1'b0;
    tick(20);
    check_eq("t6_no_emit", (n_one - b_one) + (n_two - b_two), 0);
    check_eq("t6_count", int'(fifo_count), 0);

    // Global protocol properties over the whole run
    check_eq("never_01", n_bad, 0);
    check_eq("zero_gap", n_gap, 0);
    check_eq("issue_while_busy", n_busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
